// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Reserved mode behaves like no parity.
  function automatic logic parity_on(parity_mode_e m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a synchronous flush.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, empty_q;
  logic             do_wr, do_rd;

  // A write while full is dropped even if a read frees a slot this cycle.
  assign do_wr = wr_i && !full_q && !flush_i;
  assign do_rd = rd_i && !empty_q && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_wr) wptr_d = wptr_q + AW'(1);
      if (do_rd) rptr_d = rptr_q + AW'(1);
      level_d = level_q + LVL_W'(do_wr) - LVL_W'(do_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: write FIFO plus serializer with per-frame parity, stop bits and bit period.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_wr_en,
  input  logic                          abort_tx,
  output logic                          tx,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          tx_busy,
  output logic                          tx_underrun,
  output logic                          tx_overflow
);

  import uart_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  tx_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DIV_WIDTH-1:0]  fld_q, fld_d;
  logic                  fpar_en_q, fpar_en_d;
  logic                  fpar_bit_q, fpar_bit_d;
  logic                  fstop_q, fstop_d;
  logic                  tx_q, tx_d;
  logic                  underrun_q, underrun_d;
  logic                  overflow_q, overflow_d;

  logic                  pop, start_frame, cnt_last;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [LVL_W-1:0]      fifo_level;
  logic [DIV_WIDTH-1:0]  live_ld;
  parity_mode_e          pm;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (tx_wr_en),
    .wdata_i (tx_data),
    .rd_i    (pop),
    .flush_i (abort_tx),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Counter reload value is period-1; a zero divider means one cycle per bit.
  assign live_ld  = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
  assign pm       = parity_mode_e'(parity_mode);
  assign cnt_last = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    fld_d       = fld_q;
    fpar_en_d   = fpar_en_q;
    fpar_bit_d  = fpar_bit_q;
    fstop_d     = fstop_q;
    underrun_d  = 1'b0;
    start_frame = 1'b0;
    pop         = 1'b0;

    if (state_q != IDLE && !cnt_last) cnt_d = cnt_q - DIV_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (cnt_last) begin
          state_d = DATA;
          cnt_d   = fld_q;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d   = fld_q;
          shreg_d = shreg_q >> 1;
          if (bit_q == IDX_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = fpar_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (cnt_last) begin
          state_d = STOP;
          cnt_d   = fld_q;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (cnt_last) begin
          if (bit_q == '0 && fstop_q) begin
            bit_d = IDX_W'(1);
            cnt_d = fld_q;
          end else if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame config is latched here so later input changes cannot disturb this frame.
    if (start_frame) begin
      pop        = 1'b1;
      state_d    = START;
      cnt_d      = live_ld;
      bit_d      = '0;
      shreg_d    = fifo_rdata;
      fld_d      = live_ld;
      fpar_en_d  = parity_on(pm);
      fpar_bit_d = (pm == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      fstop_d    = stop_bits;
    end

    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
      PARITY:  tx_d = fpar_bit_q;
      default: tx_d = UART_IDLE_LEVEL;
    endcase

    overflow_d = tx_wr_en && fifo_full && !abort_tx;

    if (abort_tx) begin
      state_d    = IDLE;
      pop        = 1'b0;
      cnt_d      = '0;
      bit_d      = '0;
      tx_d       = UART_IDLE_LEVEL;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      fld_q      <= '0;
      fpar_en_q  <= 1'b0;
      fpar_bit_q <= 1'b0;
      fstop_q    <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      fld_q      <= fld_d;
      fpar_en_q  <= fpar_en_d;
      fpar_bit_q <= fpar_bit_d;
      fstop_q    <= fstop_d;
      tx_q       <= tx_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx          = tx_q;
  assign tx_full     = fifo_full;
  assign tx_empty    = fifo_empty;
  assign tx_level    = fifo_level;
  assign tx_busy     = (state_q != IDLE);
  assign tx_underrun = underrun_q;
  assign tx_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomised scoreboard bench: expected frames are queued on write and decoded off the line.
module tb_uart_tx_engine;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int DIVW  = 16;
  localparam int LVLW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DIVW-1:0] baud_div = 16'd4;
  logic [1:0]      parity_mode = 2'd0;
  logic            stop_bits = 1'b0;
  logic [DW-1:0]   tx_data = '0;
  logic            tx_wr_en = 1'b0;
  logic            abort_tx = 1'b0;
  logic            tx, tx_full, tx_empty, tx_busy, tx_underrun, tx_overflow;
  logic [LVLW-1:0] tx_level;

  uart_tx_engine #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .tx_data(tx_data), .tx_wr_en(tx_wr_en), .abort_tx(abort_tx),
    .tx(tx), .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level),
    .tx_busy(tx_busy), .tx_underrun(tx_underrun), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            par;
    int            stp;
    int            div;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0, errors = 0;
  int underruns = 0, overflows = 0, b2b = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Line monitor: a frame is the list of bit levels, each held div cycles.
  bit     mon_in = 0;
  logic   mon_bits[$];
  int     mon_div, mon_cyc, mon_len, mon_bad_cyc;
  bit     mon_bad;
  logic   mon_bad_exp;
  frame_t mon_f;
  int     idle_run = 1;

  always @(negedge clk) begin
    if (!rst_n || abort_tx) begin
      mon_in   = 0;
      idle_run = 1;
    end else begin
      if (!mon_in && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          mon_f = '{d: '0, par: 0, stp: 0, div: 1};
          checks++; errors++;
          $display("FAIL unexpected_frame: start bit seen with no frame expected");
        end else begin
          mon_f = exp_q.pop_front();
        end
        mon_div = (mon_f.div == 0) ? 1 : mon_f.div;
        mon_bits.delete();
        mon_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) mon_bits.push_back(mon_f.d[i]);
        if (mon_f.par == 1) mon_bits.push_back(^mon_f.d);
        if (mon_f.par == 2) mon_bits.push_back(~^mon_f.d);
        mon_bits.push_back(1'b1);
        if (mon_f.stp != 0) mon_bits.push_back(1'b1);
        mon_len = mon_bits.size() * mon_div;
        if (idle_run == 0) b2b++;
        mon_in  = 1;
        mon_cyc = 0;
        mon_bad = 0;
      end else if (!mon_in) begin
        idle_run++;
      end
      if (mon_in) begin
        if (tx !== mon_bits[mon_cyc / mon_div] && !mon_bad) begin
          mon_bad     = 1;
          mon_bad_cyc = mon_cyc;
          mon_bad_exp = mon_bits[mon_cyc / mon_div];
        end
        mon_cyc++;
        if (mon_cyc == mon_len) begin
          checks++;
          if (mon_bad) begin
            errors++;
            $display("FAIL frame %02h par %0d stp %0d div %0d: cycle %0d got %b expected %b",
                     mon_f.d, mon_f.par, mon_f.stp, mon_div, mon_bad_cyc, !mon_bad_exp, mon_bad_exp);
          end
          mon_in   = 0;
          idle_run = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_underrun) underruns++;
      if (tx_overflow) overflows++;
    end
  end

  task automatic set_cfg(input int div, input int par, input int stp);
    baud_div    = DIVW'(div);
    parity_mode = 2'(par);
    stop_bits   = 1'(stp);
  endtask

  // Inputs change 1 time unit after a rising edge; wr returns at the same phase.
  task automatic wr(input logic [DW-1:0] d, input bit acc);
    tx_data  = d;
    tx_wr_en = 1'b1;
    if (acc) exp_q.push_back('{d: d, par: int'(parity_mode), stp: int'(stop_bits), div: int'(baud_div)});
    @(posedge clk); #1;
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (!tx_busy && tx_empty && !mon_in) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", bound);
    end
    repeat (2) @(negedge clk);
    chk("drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_tx_low();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (tx === 1'b0) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL start_timeout: tx never went low");
    end
  endtask

  // Called right after a write into an empty idle engine.
  task automatic frame_timing(output int lat, output int len);
    int k = 0;
    lat = -1;
    len = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx_busy) len++;
      if (lat < 0 && tx === 1'b0) lat = k;
      k++;
      if (!tx_busy && len > 0) break;
    end
  endtask

  initial begin
    int lat, len, u0, o0, b0, occ;
    bit acc;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_flags", {tx_full, tx_empty, tx_busy, tx_underrun, tx_overflow}, 5'b01000);
    chk("rst_level", tx_level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8N1, div 4
    set_cfg(4, 0, 0);
    u0 = underruns;
    wr(8'hA5, 1);
    frame_timing(lat, len);
    chk("t1_latency", lat, 2);
    chk("t1_busy_len", len, 40);
    wait_idle(500);
    chk("t1_underrun", underruns - u0, 1);

    // even, odd parity, then two stop bits
    set_cfg(4, 1, 0);
    wr(8'h07, 1);
    wait_idle(500);
    set_cfg(4, 2, 0);
    wr(8'h07, 1);
    wait_idle(500);
    set_cfg(4, 1, 1);
    wr(8'h07, 1);
    frame_timing(lat, len);
    chk("t2_busy_len", len, 48);
    wait_idle(500);

    // fill FIFO behind a slow frame; last word overflows
    set_cfg(100, 0, 0);
    o0 = overflows; b0 = b2b; u0 = underruns; occ = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      acc = (i == 0) || (occ < DEPTH);
      if (i > 0 && acc) occ++;
      wr(DW'(i), acc);
    end
    @(negedge clk);
    chk("t3_full", tx_full, 1);
    chk("t3_level", tx_level, DEPTH);
    repeat (2) @(negedge clk);
    chk("t3_overflow", overflows - o0, 1);
    @(posedge clk); #1;
    wait_idle(30000);
    chk("t3_back2back", b2b - b0, DEPTH);
    chk("t3_underrun", underruns - u0, 1);

    // abort during data bit 3 with words queued; same-cycle write is dropped
    set_cfg(4, 0, 0);
    u0 = underruns; o0 = overflows;
    for (int i = 0; i < 6; i++) wr(DW'($urandom), 1);
    wait_tx_low();
    repeat (17) @(negedge clk);
    @(posedge clk); #1;
    abort_tx = 1'b1;
    tx_wr_en = 1'b1;
    tx_data  = 8'h55;
    @(posedge clk); #1;
    abort_tx = 1'b0;
    tx_wr_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_tx", tx, 1);
    chk("t4_busy", tx_busy, 0);
    chk("t4_empty", tx_empty, 1);
    chk("t4_level", tx_level, 0);
    repeat (20) @(negedge clk);
    chk("t4_no_underrun", underruns - u0, 0);
    chk("t4_no_overflow", overflows - o0, 0);
    @(posedge clk); #1;

    // parity change mid-frame applies only to the next frame
    set_cfg(2, 0, 0);
    u0 = underruns;
    wr(8'h3C, 1);
    wait_tx_low();
    @(posedge clk); #1;
    parity_mode = 2'd1;
    wr(8'hC3, 1);
    wait_idle(500);
    chk("t5_underrun", underruns - u0, 1);

    // asynchronous reset mid-data
    set_cfg(4, 0, 0);
    wr(8'h5A, 1);
    wait_tx_low();
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tx", tx, 1);
    chk("t6_flags", {tx_full, tx_empty, tx_busy, tx_underrun, tx_overflow}, 5'b01000);
    chk("t6_level", tx_level, 0);
    @(posedge clk); #1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // random bursts under random per-burst configuration
    for (int b = 0; b < 10; b++) begin
      int n;
      set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 1));
      n  = $urandom_range(1, 6);
      u0 = underruns; o0 = overflows;
      for (int i = 0; i < n; i++) wr(DW'($urandom), 1);
      wait_idle(2000);
      chk("rnd_underrun", underruns - u0, 1);
      chk("rnd_overflow", overflows - o0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
